// File: rtl/rx_frame_buffer_pkg.sv
// Shared definitions for the receive frame buffer.
// - wr_state_t      : write-side FSM encoding (IDLE / RECV / DISCARD)
// - DEFAULT_MIN_LEN : shortest frame accepted, in bytes
// - DEFAULT_MAX_LEN : longest frame accepted, in bytes
// - EVT_OK/EVT_DROP : indices of the frame event counters
// - sat_inc()       : 16-bit saturating increment
package rx_frame_buffer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RECV    = 2'd1,
    ST_DISCARD = 2'd2
  } wr_state_t;

  localparam int DEFAULT_MIN_LEN = 64;
  localparam int DEFAULT_MAX_LEN = 1518;

  localparam int NUM_EVT  = 2;
  localparam int EVT_OK   = 0;
  localparam int EVT_DROP = 1;

  function automatic logic [15:0] sat_inc(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/fb_dpram.sv
// Simple dual-port storage array for the frame buffer.
// Ports:
//   clk   - single clock for both ports
//   we    - write enable; waddr/wdata written on the rising edge
//   re    - read enable; rdata loads mem[raddr] on the rising edge
//   rdata - registered read data (holds when re is low)
// No reset on the array or read register so it maps onto block RAM.
module fb_dpram #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 9
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/rx_frame_buffer.sv
// Store-and-forward receive frame buffer.
// Bytes from the MAC are written speculatively; a frame becomes readable
// only once its last byte arrives with good status and a legal length.
// Bad, runt, oversize or overflowing frames are rolled back by restoring
// the write pointer to the last commit point.
// Ports:
//   rx_mac_clk, reset           - clock, asynchronous active-high reset
//   rx_mac_valid/data/last/error- MAC byte stream (no backpressure)
//   out_valid/data/last/ready   - committed byte stream to downstream
//   frames_ok, frames_dropped   - saturating frame counters
//   drop_pulse                  - one-cycle strobe per dropped frame
module rx_frame_buffer
  import rx_frame_buffer_pkg::*;
#(
  parameter int ADDR_W  = 11,
  parameter int MIN_LEN = DEFAULT_MIN_LEN,
  parameter int MAX_LEN = DEFAULT_MAX_LEN
) (
  input  logic        rx_mac_clk,
  input  logic        reset,
  input  logic        rx_mac_valid,
  input  logic [7:0]  rx_mac_data,
  input  logic        rx_mac_last,
  input  logic        rx_mac_error,
  output logic        out_valid,
  output logic [7:0]  out_data,
  output logic        out_last,
  input  logic        out_ready,
  output logic [15:0] frames_ok,
  output logic [15:0] frames_dropped,
  output logic        drop_pulse
);

  localparam int PTR_W = ADDR_W + 1;
  localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(2 ** ADDR_W);
  localparam int LEN_W = $clog2(MAX_LEN + 2);

  // ---------------------------------------------------------------
  // Write side
  // ---------------------------------------------------------------
  wr_state_t        state_reg, state_next;
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] wr_commit_reg, wr_commit_next;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [LEN_W-1:0] len_reg, len_next, len_inc;
  logic [PTR_W-1:0] used, free;
  logic             mem_we;
  logic             commit_evt;
  logic             drop_evt;

  // Pointers carry one extra wrap bit so full and empty are distinct.
  assign used    = wr_ptr_reg - rd_ptr_reg;
  assign free    = DEPTH_P - used;
  assign len_inc = len_reg + LEN_W'(1);

  always_comb begin
    state_next     = state_reg;
    wr_ptr_next    = wr_ptr_reg;
    wr_commit_next = wr_commit_reg;
    len_next       = len_reg;
    mem_we         = 1'b0;
    commit_evt     = 1'b0;
    drop_evt       = 1'b0;

    case (state_reg)
      ST_IDLE, ST_RECV: begin
        if (rx_mac_valid) begin
          if (free == '0 || len_inc > LEN_W'(MAX_LEN)) begin
            // No room or frame too long: roll back, swallow the rest.
            drop_evt    = 1'b1;
            wr_ptr_next = wr_commit_reg;
            len_next    = '0;
            state_next  = rx_mac_last ? ST_IDLE : ST_DISCARD;
          end else begin
            mem_we      = 1'b1;
            wr_ptr_next = wr_ptr_reg + PTR_W'(1);
            len_next    = len_inc;
            state_next  = ST_RECV;
            if (rx_mac_last) begin
              state_next = ST_IDLE;
              len_next   = '0;
              if (rx_mac_error || len_inc < LEN_W'(MIN_LEN)) begin
                drop_evt    = 1'b1;
                wr_ptr_next = wr_commit_reg;
              end else begin
                commit_evt     = 1'b1;
                wr_commit_next = wr_ptr_reg + PTR_W'(1);
              end
            end
          end
        end
      end
      ST_DISCARD: begin
        if (rx_mac_valid && rx_mac_last) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge rx_mac_clk or posedge reset) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      wr_ptr_reg    <= '0;
      wr_commit_reg <= '0;
      len_reg       <= '0;
      drop_pulse    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      wr_ptr_reg    <= wr_ptr_next;
      wr_commit_reg <= wr_commit_next;
      len_reg       <= len_next;
      drop_pulse    <= drop_evt;
    end
  end

  // ---------------------------------------------------------------
  // Frame event counters
  // ---------------------------------------------------------------
  logic [NUM_EVT-1:0] evt_pulse;
  logic [15:0]        evt_cnt [NUM_EVT];

  assign evt_pulse[EVT_OK]   = commit_evt;
  assign evt_pulse[EVT_DROP] = drop_evt;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_EVT; gi++) begin : g_evt_cnt
      logic [15:0] cnt_reg;
      always_ff @(posedge rx_mac_clk or posedge reset) begin
        if (reset) begin
          cnt_reg <= '0;
        end else if (evt_pulse[gi]) begin
          cnt_reg <= sat_inc(cnt_reg);
        end
      end
      assign evt_cnt[gi] = cnt_reg;
    end
  endgenerate

  assign frames_ok      = evt_cnt[EVT_OK];
  assign frames_dropped = evt_cnt[EVT_DROP];

  // ---------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------
  logic       rd_en;
  logic [8:0] ram_q;

  fb_dpram #(
    .ADDR_W (ADDR_W),
    .DATA_W (9)
  ) u_dpram (
    .clk   (rx_mac_clk),
    .we    (mem_we),
    .waddr (wr_ptr_reg[ADDR_W-1:0]),
    .wdata ({rx_mac_last, rx_mac_data}),
    .re    (rd_en),
    .raddr (rd_ptr_reg[ADDR_W-1:0]),
    .rdata (ram_q)
  );

  // ---------------------------------------------------------------
  // Read side: RAM read register feeds an output register, with a
  // prefetch register absorbing the read that is in flight when the
  // output stalls.
  // ---------------------------------------------------------------
  logic       inflight_reg;
  logic       pf_valid_reg;
  logic [8:0] pf_reg;
  logic       avail;
  logic       pop;
  logic       load_out;
  logic [1:0] occ;

  assign avail    = (rd_ptr_reg != wr_commit_reg);
  assign pop      = out_valid && out_ready;
  assign load_out = !out_valid || pop;
  // Bytes held in the stages or landing from the RAM this cycle.
  assign occ      = {1'b0, out_valid} + {1'b0, pf_valid_reg} + {1'b0, inflight_reg};
  // A new read is only issued if both stages can still hold it once it
  // lands, so nothing read from the array is ever lost.
  assign rd_en    = avail && (occ <= ({1'b0, pop} + 2'd1));

  always_ff @(posedge rx_mac_clk or posedge reset) begin
    if (reset) begin
      rd_ptr_reg   <= '0;
      inflight_reg <= 1'b0;
      pf_valid_reg <= 1'b0;
      pf_reg       <= '0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_last     <= 1'b0;
    end else begin
      inflight_reg <= rd_en;
      if (rd_en) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end

      if (load_out) begin
        if (pf_valid_reg) begin
          {out_last, out_data} <= pf_reg;
          out_valid            <= 1'b1;
          pf_valid_reg         <= inflight_reg;
          if (inflight_reg) begin
            pf_reg <= ram_q;
          end
        end else if (inflight_reg) begin
          {out_last, out_data} <= ram_q;
          out_valid            <= 1'b1;
        end else begin
          out_valid <= 1'b0;
        end
      end else if (inflight_reg) begin
        // Output is stalled; park the arriving byte.
        pf_reg       <= ram_q;
        pf_valid_reg <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rx_frame_buffer.sv
module tb_rx_frame_buffer;

  logic        clk;
  logic        reset;
  logic        rx_mac_valid;
  logic [7:0]  rx_mac_data;
  logic        rx_mac_last;
  logic        rx_mac_error;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_last;
  logic        out_ready;
  logic [15:0] frames_ok;
  logic [15:0] frames_dropped;
  logic        drop_pulse;

  int          check_cnt = 0;
  int          pass_cnt  = 0;
  int          cycle_cnt = 0;
  int          drop_cnt  = 0;
  int          first_valid_cyc = 0;
  bit          seen_valid = 0;
  logic [8:0]  rx_q [$];
  logic [8:0]  exp_q [$];

  rx_frame_buffer dut (
    .rx_mac_clk     (clk),
    .reset          (reset),
    .rx_mac_valid   (rx_mac_valid),
    .rx_mac_data    (rx_mac_data),
    .rx_mac_last    (rx_mac_last),
    .rx_mac_error   (rx_mac_error),
    .out_valid      (out_valid),
    .out_data       (out_data),
    .out_last       (out_last),
    .out_ready      (out_ready),
    .frames_ok      (frames_ok),
    .frames_dropped (frames_dropped),
    .drop_pulse     (drop_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  // Inputs change only at posedge+1, so negedge values are what the
  // next rising edge will act on.
  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid && out_ready) rx_q.push_back({out_last, out_data});
      if (drop_pulse) drop_cnt++;
      if (out_valid && !seen_valid) begin
        seen_valid      = 1'b1;
        first_valid_cyc = cycle_cnt;
      end
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic void push_frame(int len, int base);
    for (int i = 0; i < len; i++) exp_q.push_back({(i == len - 1), 8'(base + i)});
  endfunction

  // Called and returns at posedge+1.
  task automatic send_frame(int len, bit err, int base);
    $display("tx frame len=%0d err=%0b base=%02h t=%0t", len, err, 8'(base), $time);
    for (int i = 0; i < len; i++) begin
      rx_mac_valid = 1'b1;
      rx_mac_data  = 8'(base + i);
      rx_mac_last  = (i == len - 1);
      rx_mac_error = err && (i == len - 1);
      @(posedge clk); #1;
    end
    rx_mac_valid = 1'b0;
    rx_mac_last  = 1'b0;
    rx_mac_error = 1'b0;
  endtask

  task automatic wait_rx(int n, int budget);
    for (int t = 0; t < budget && rx_q.size() < n; t++) @(posedge clk);
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    rx_q.delete();
    exp_q.delete();
    drop_cnt   = 0;
    seen_valid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    check_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %0b exp 0", out_valid); else pass_cnt++;
    check_cnt++; if (out_data !== 8'h00) $display("FAIL reset_out_data got %02h exp 00", out_data); else pass_cnt++;
    check_cnt++; if (out_last !== 1'b0) $display("FAIL reset_out_last got %0b exp 0", out_last); else pass_cnt++;
    check_cnt++; if (frames_ok !== 16'd0) $display("FAIL reset_frames_ok got %0d exp 0", frames_ok); else pass_cnt++;
    check_cnt++; if (frames_dropped !== 16'd0) $display("FAIL reset_frames_dropped got %0d exp 0", frames_dropped); else pass_cnt++;
    check_cnt++; if (drop_pulse !== 1'b0) $display("FAIL reset_drop_pulse got %0b exp 0", drop_pulse); else pass_cnt++;
    reset = 1'b0;
  endtask

  task automatic test_good_frame();
    int commit_cyc;
    int bad;
    do_reset();
    out_ready = 1'b1;
    send_frame(64, 1'b0, 8'h00);
    commit_cyc = cycle_cnt;
    push_frame(64, 8'h00);
    wait_rx(64, 200);
    check_cnt++;
    if (!seen_valid || first_valid_cyc < commit_cyc || first_valid_cyc > commit_cyc + 2)
      $display("FAIL good_latency got valid at cycle %0d (seen=%0b) exp %0d..%0d", first_valid_cyc, seen_valid, commit_cyc, commit_cyc + 2);
    else pass_cnt++;
    check_cnt++; if (rx_q.size() != exp_q.size()) $display("FAIL good_count got %0d exp %0d", rx_q.size(), exp_q.size()); else pass_cnt++;
    bad = -1;
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) if (bad < 0 && rx_q[i] !== exp_q[i]) bad = i;
    check_cnt++; if (bad >= 0) $display("FAIL good_data idx %0d got %03h exp %03h", bad, rx_q[bad], exp_q[bad]); else pass_cnt++;
    check_cnt++; if (frames_ok !== 16'd1) $display("FAIL good_frames_ok got %0d exp 1", frames_ok); else pass_cnt++;
    check_cnt++; if (frames_dropped !== 16'd0) $display("FAIL good_frames_dropped got %0d exp 0", frames_dropped); else pass_cnt++;
  endtask

  task automatic test_error_drop();
    int bad;
    do_reset();
    out_ready = 1'b1;
    send_frame(100, 1'b1, 8'h80);
    send_frame(64, 1'b0, 8'h40);
    push_frame(64, 8'h40);
    wait_rx(64, 300);
    check_cnt++; if (rx_q.size() != exp_q.size()) $display("FAIL err_count got %0d exp %0d", rx_q.size(), exp_q.size()); else pass_cnt++;
    bad = -1;
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) if (bad < 0 && rx_q[i] !== exp_q[i]) bad = i;
    check_cnt++; if (bad >= 0) $display("FAIL err_data idx %0d got %03h exp %03h", bad, rx_q[bad], exp_q[bad]); else pass_cnt++;
    check_cnt++; if (frames_dropped !== 16'd1) $display("FAIL err_frames_dropped got %0d exp 1", frames_dropped); else pass_cnt++;
    check_cnt++; if (drop_cnt != 1) $display("FAIL err_drop_pulse_cycles got %0d exp 1", drop_cnt); else pass_cnt++;
    check_cnt++; if (frames_ok !== 16'd1) $display("FAIL err_frames_ok got %0d exp 1", frames_ok); else pass_cnt++;
  endtask

  task automatic test_len_drop();
    int bad;
    do_reset();
    out_ready = 1'b1;
    send_frame(63, 1'b0, 8'h00);
    send_frame(1519, 1'b0, 8'h00);
    repeat (20) @(posedge clk);
    #1;
    check_cnt++; if (frames_dropped !== 16'd2) $display("FAIL len_frames_dropped got %0d exp 2", frames_dropped); else pass_cnt++;
    check_cnt++; if (drop_cnt != 2) $display("FAIL len_drop_pulse_cycles got %0d exp 2", drop_cnt); else pass_cnt++;
    check_cnt++; if (rx_q.size() != 0) $display("FAIL len_nothing_out got %0d bytes exp 0", rx_q.size()); else pass_cnt++;
    check_cnt++; if (frames_ok !== 16'd0) $display("FAIL len_frames_ok got %0d exp 0", frames_ok); else pass_cnt++;
    // Write pointer must have been rolled back: next frames come out intact.
    send_frame(64, 1'b0, 8'hA0);
    send_frame(1518, 1'b0, 8'h03);
    push_frame(64, 8'hA0);
    push_frame(1518, 8'h03);
    wait_rx(64 + 1518, 2000);
    check_cnt++; if (rx_q.size() != exp_q.size()) $display("FAIL len_after_count got %0d exp %0d", rx_q.size(), exp_q.size()); else pass_cnt++;
    bad = -1;
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) if (bad < 0 && rx_q[i] !== exp_q[i]) bad = i;
    check_cnt++; if (bad >= 0) $display("FAIL len_after_data idx %0d got %03h exp %03h", bad, rx_q[bad], exp_q[bad]); else pass_cnt++;
    check_cnt++; if (frames_ok !== 16'd2) $display("FAIL len_max_frames_ok got %0d exp 2", frames_ok); else pass_cnt++;
  endtask

  task automatic test_overflow();
    int bad;
    do_reset();
    out_ready = 1'b0;
    send_frame(1000, 1'b0, 8'h00);
    send_frame(1000, 1'b0, 8'h10);
    send_frame(100, 1'b0, 8'h20);
    push_frame(1000, 8'h00);
    push_frame(1000, 8'h10);
    repeat (5) @(posedge clk);
    #1;
    check_cnt++; if (frames_ok !== 16'd2) $display("FAIL ovf_frames_ok got %0d exp 2", frames_ok); else pass_cnt++;
    check_cnt++; if (frames_dropped !== 16'd1) $display("FAIL ovf_frames_dropped got %0d exp 1", frames_dropped); else pass_cnt++;
    check_cnt++; if (out_valid !== 1'b1) $display("FAIL ovf_stall_valid got %0b exp 1", out_valid); else pass_cnt++;
    repeat (3) @(posedge clk);
    #1;
    check_cnt++; if ({out_valid, out_last, out_data} !== 10'h200) $display("FAIL ovf_hold got v=%0b l=%0b d=%02h exp v=1 l=0 d=00", out_valid, out_last, out_data); else pass_cnt++;
    out_ready = 1'b1;
    wait_rx(2000, 2600);
    check_cnt++; if (rx_q.size() != exp_q.size()) $display("FAIL ovf_count got %0d exp %0d", rx_q.size(), exp_q.size()); else pass_cnt++;
    bad = -1;
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) if (bad < 0 && rx_q[i] !== exp_q[i]) bad = i;
    check_cnt++; if (bad >= 0) $display("FAIL ovf_data idx %0d got %03h exp %03h", bad, rx_q[bad], exp_q[bad]); else pass_cnt++;
  endtask

  task automatic test_random_ready();
    int bad;
    bit tx_done;
    do_reset();
    tx_done = 1'b0;
    fork
      begin
        for (int f = 0; f < 50; f++) begin
          send_frame(64, 1'b0, f * 5);
          push_frame(64, f * 5);
        end
        tx_done = 1'b1;
      end
      begin
        while (!tx_done) begin
          out_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk); #1;
        end
      end
    join
    out_ready = 1'b1;
    wait_rx(3200, 4000);
    check_cnt++; if (rx_q.size() != exp_q.size()) $display("FAIL rand_count got %0d exp %0d", rx_q.size(), exp_q.size()); else pass_cnt++;
    bad = -1;
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) if (bad < 0 && rx_q[i] !== exp_q[i]) bad = i;
    check_cnt++; if (bad >= 0) $display("FAIL rand_data idx %0d got %03h exp %03h", bad, rx_q[bad], exp_q[bad]); else pass_cnt++;
    check_cnt++; if (frames_ok !== 16'd50) $display("FAIL rand_frames_ok got %0d exp 50", frames_ok); else pass_cnt++;
    check_cnt++; if (frames_dropped !== 16'd0) $display("FAIL rand_frames_dropped got %0d exp 0", frames_dropped); else pass_cnt++;
  endtask

  task automatic test_reset_midframe();
    do_reset();
    out_ready = 1'b0;
    send_frame(64, 1'b0, 8'h55);
    $display("tx partial frame 30 bytes then reset t=%0t", $time);
    for (int i = 0; i < 30; i++) begin
      rx_mac_valid = 1'b1;
      rx_mac_data  = 8'(8'h90 + i);
      rx_mac_last  = 1'b0;
      @(posedge clk); #1;
    end
    check_cnt++; if (frames_ok !== 16'd1) $display("FAIL rst_pre_frames_ok got %0d exp 1", frames_ok); else pass_cnt++;
    check_cnt++; if (out_valid !== 1'b1) $display("FAIL rst_pre_out_valid got %0b exp 1", out_valid); else pass_cnt++;
    rx_mac_data = 8'hAE;
    #2;
    reset = 1'b1;
    #1;
    check_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got %0b exp 0", out_valid); else pass_cnt++;
    check_cnt++; if (frames_ok !== 16'd0) $display("FAIL rst_frames_ok got %0d exp 0", frames_ok); else pass_cnt++;
    check_cnt++; if (frames_dropped !== 16'd0) $display("FAIL rst_frames_dropped got %0d exp 0", frames_dropped); else pass_cnt++;
    @(posedge clk); #1;
    rx_mac_data = 8'hAF;
    @(posedge clk); #1;
    reset = 1'b0;
    rx_q.delete();
    drop_cnt = 0;
    // Remaining 32 bytes form a new frame, a runt, so it is dropped.
    for (int i = 0; i < 32; i++) begin
      rx_mac_valid = 1'b1;
      rx_mac_data  = 8'(8'hB0 + i);
      rx_mac_last  = (i == 31);
      @(posedge clk); #1;
    end
    rx_mac_valid = 1'b0;
    rx_mac_last  = 1'b0;
    out_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check_cnt++; if (rx_q.size() != 0) $display("FAIL rst_nothing_out got %0d bytes exp 0", rx_q.size()); else pass_cnt++;
    check_cnt++; if (frames_ok !== 16'd0) $display("FAIL rst_post_frames_ok got %0d exp 0", frames_ok); else pass_cnt++;
    check_cnt++; if (frames_dropped !== 16'd1) $display("FAIL rst_post_frames_dropped got %0d exp 1", frames_dropped); else pass_cnt++;
  endtask

  initial begin
    reset        = 1'b1;
    rx_mac_valid = 1'b0;
    rx_mac_data  = 8'h00;
    rx_mac_last  = 1'b0;
    rx_mac_error = 1'b0;
    out_ready    = 1'b0;
    test_reset();
    test_good_frame();
    test_error_drop();
    test_len_drop();
    test_overflow();
    test_random_ready();
    test_reset_midframe();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
